// File: rtl/ovl_next_stim_gen.sv
// ovl_next_stim_gen: stimulus transmitter for the "next" checker protocol.
// Each accepted trig launches one transaction through a tagged delay
// pipeline; start_event and test_expr are driven from the pipeline taps so
// that test_expr follows start_event by NUM_CKS cycles. Error modes
// (drop, late, orphan) produce deliberately violating sequences.
module ovl_next_stim_gen #(
  parameter int NUM_CKS       = 1,
  parameter int ALLOW_OVERLAP = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trig,
  input  logic [1:0]       err_mode,
  output logic             trig_ready,
  output logic             start_event,
  output logic             test_expr,
  output logic [4:0]       in_flight,
  output logic [CNT_W-1:0] txn_done,
  output logic [7:0]       rej_cnt
);

  // Stage k holds a transaction during cycle t+1+k; the extra stage past
  // NUM_CKS exists so a late transaction can still be seen when it retires.
  localparam int DEPTH = NUM_CKS + 2;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_LATE   = 2'b10;
  localparam logic [1:0] MODE_ORPHAN = 2'b11;

  logic [DEPTH-1:0] stg_vld;
  logic [1:0]       stg_mode [DEPTH];

  logic       accept;
  logic       reject;
  logic       start_next;
  logic       test_next;
  logic       retire_norm;
  logic       retire_late;
  logic [1:0] retire_cnt;

  // Without overlap only an empty generator may take a new transaction.
  assign trig_ready = (ALLOW_OVERLAP != 0) ? 1'b1 : (in_flight == 5'd0);

  // Acceptance, next output values and retirement decoded from the pipeline.
  always_comb begin
    accept      = trig && trig_ready;
    reject      = trig && !trig_ready;
    start_next  = accept && (err_mode != MODE_ORPHAN);
    test_next   = (stg_vld[NUM_CKS-1] &&
                   ((stg_mode[NUM_CKS-1] == MODE_NORMAL) ||
                    (stg_mode[NUM_CKS-1] == MODE_ORPHAN))) ||
                  (stg_vld[NUM_CKS] && (stg_mode[NUM_CKS] == MODE_LATE));
    retire_norm = stg_vld[NUM_CKS] && (stg_mode[NUM_CKS] != MODE_LATE);
    retire_late = stg_vld[NUM_CKS+1] && (stg_mode[NUM_CKS+1] == MODE_LATE);
    retire_cnt  = {1'b0, retire_norm} + {1'b0, retire_late};
  end

  // Delay pipeline: shift valid and captured mode one stage per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stg_mode[i] <= 2'b00;
      end
    end else begin
      stg_vld     <= {stg_vld[DEPTH-2:0], accept};
      stg_mode[0] <= err_mode;
      for (int i = 1; i < DEPTH; i++) begin
        stg_mode[i] <= stg_mode[i-1];
      end
    end
  end

  // Registered checker outputs and status counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_event <= 1'b0;
      test_expr   <= 1'b0;
      in_flight   <= 5'd0;
      txn_done    <= '0;
      rej_cnt     <= 8'd0;
    end else begin
      start_event <= start_next;
      test_expr   <= test_next;
      in_flight   <= in_flight + {4'b0000, accept} - {3'b000, retire_cnt};
      txn_done    <= txn_done + CNT_W'(retire_cnt);
      if (reject && (rej_cnt != 8'hFF)) begin
        rej_cnt <= rej_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ovl_next_stim_gen.sv
// Directed testbench for ovl_next_stim_gen with one DUT instance per
// parameter set; all instances share clock and reset.
module tb_ovl_next_stim_gen;

  logic clk = 1'b0;
  logic reset_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instance A: NUM_CKS=3, overlap
  logic       trig_a, rdy_a, se_a, te_a;
  logic [1:0] mode_a;
  logic [4:0] if_a;
  logic [15:0] done_a;
  logic [7:0] rej_a;
  // Instance B: NUM_CKS=2, overlap
  logic       trig_b, rdy_b, se_b, te_b;
  logic [1:0] mode_b;
  logic [4:0] if_b;
  logic [15:0] done_b;
  logic [7:0] rej_b;
  // Instance C: NUM_CKS=2, no overlap
  logic       trig_c, rdy_c, se_c, te_c;
  logic [1:0] mode_c;
  logic [4:0] if_c;
  logic [15:0] done_c;
  logic [7:0] rej_c;
  // Instance D: NUM_CKS=1, no overlap
  logic       trig_d, rdy_d, se_d, te_d;
  logic [1:0] mode_d;
  logic [4:0] if_d;
  logic [15:0] done_d;
  logic [7:0] rej_d;
  // Instance E: NUM_CKS=4, overlap
  logic       trig_e, rdy_e, se_e, te_e;
  logic [1:0] mode_e;
  logic [4:0] if_e;
  logic [15:0] done_e;
  logic [7:0] rej_e;

  ovl_next_stim_gen #(.NUM_CKS(3), .ALLOW_OVERLAP(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .trig(trig_a), .err_mode(mode_a),
    .trig_ready(rdy_a), .start_event(se_a), .test_expr(te_a),
    .in_flight(if_a), .txn_done(done_a), .rej_cnt(rej_a));

  ovl_next_stim_gen #(.NUM_CKS(2), .ALLOW_OVERLAP(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .trig(trig_b), .err_mode(mode_b),
    .trig_ready(rdy_b), .start_event(se_b), .test_expr(te_b),
    .in_flight(if_b), .txn_done(done_b), .rej_cnt(rej_b));

  ovl_next_stim_gen #(.NUM_CKS(2), .ALLOW_OVERLAP(0), .CNT_W(16)) dut_c (
    .clk(clk), .reset_n(reset_n), .trig(trig_c), .err_mode(mode_c),
    .trig_ready(rdy_c), .start_event(se_c), .test_expr(te_c),
    .in_flight(if_c), .txn_done(done_c), .rej_cnt(rej_c));

  ovl_next_stim_gen #(.NUM_CKS(1), .ALLOW_OVERLAP(0), .CNT_W(16)) dut_d (
    .clk(clk), .reset_n(reset_n), .trig(trig_d), .err_mode(mode_d),
    .trig_ready(rdy_d), .start_event(se_d), .test_expr(te_d),
    .in_flight(if_d), .txn_done(done_d), .rej_cnt(rej_d));

  ovl_next_stim_gen #(.NUM_CKS(4), .ALLOW_OVERLAP(1), .CNT_W(16)) dut_e (
    .clk(clk), .reset_n(reset_n), .trig(trig_e), .err_mode(mode_e),
    .trig_ready(rdy_e), .start_event(se_e), .test_expr(te_e),
    .in_flight(if_e), .txn_done(done_e), .rej_cnt(rej_e));

  // Pulse reset for two cycles and leave the bench 1ns after a posedge.
  task automatic do_reset();
    trig_a = 1'b0; trig_b = 1'b0; trig_c = 1'b0; trig_d = 1'b0; trig_e = 1'b0;
    mode_a = 2'b00; mode_b = 2'b00; mode_c = 2'b00; mode_d = 2'b00; mode_e = 2'b00;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Outputs while reset is held low.
  task automatic test_reset();
    trig_a = 1'b0; trig_b = 1'b0; trig_c = 1'b0; trig_d = 1'b0; trig_e = 1'b0;
    mode_a = 2'b00; mode_b = 2'b00; mode_c = 2'b00; mode_d = 2'b00; mode_e = 2'b00;
    reset_n = 1'b0;
    #3;
    total++;
    if ({se_a, te_a, if_a, done_a, rej_a} !== 31'd0) begin
      bad++;
      $display("[TB] FAIL reset_a outputs got=%h exp=0", {se_a, te_a, if_a, done_a, rej_a});
    end
    total++;
    if ({rdy_a, rdy_c, rdy_d} !== 3'b111) begin
      bad++;
      $display("[TB] FAIL reset trig_ready got=%b exp=111", {rdy_a, rdy_c, rdy_d});
    end
    total++;
    if ({se_c, te_c, if_c, done_c, rej_c} !== 31'd0) begin
      bad++;
      $display("[TB] FAIL reset_c outputs got=%h exp=0", {se_c, te_c, if_c, done_c, rej_c});
    end
    do_reset();
  endtask

  // Single normal transaction, NUM_CKS=3.
  task automatic test_single();
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      trig_a = (c == 10);
      mode_a = 2'b00;
      @(negedge clk);
      total++;
      if (se_a !== (c == 11)) begin
        bad++;
        $display("[TB] FAIL single se c=%0d got=%b exp=%b", c, se_a, (c == 11));
      end
      total++;
      if (te_a !== (c == 14)) begin
        bad++;
        $display("[TB] FAIL single te c=%0d got=%b exp=%b", c, te_a, (c == 14));
      end
      total++;
      if (if_a !== ((c >= 11 && c <= 14) ? 5'd1 : 5'd0)) begin
        bad++;
        $display("[TB] FAIL single in_flight c=%0d got=%0d", c, if_a);
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (done_a !== 16'd1) begin
      bad++;
      $display("[TB] FAIL single txn_done got=%0d exp=1", done_a);
    end
    total++;
    if (rej_a !== 8'd0) begin
      bad++;
      $display("[TB] FAIL single rej_cnt got=%0d exp=0", rej_a);
    end
  endtask

  // Back-to-back overlapping transactions, NUM_CKS=2.
  task automatic test_back_to_back();
    int exp_if [15];
    exp_if = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 2, 1, 0, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 15; c++) begin
      trig_b = (c >= 5 && c <= 7);
      mode_b = 2'b00;
      @(negedge clk);
      total++;
      if (se_b !== (c >= 6 && c <= 8)) begin
        bad++;
        $display("[TB] FAIL b2b se c=%0d got=%b", c, se_b);
      end
      total++;
      if (te_b !== (c >= 8 && c <= 10)) begin
        bad++;
        $display("[TB] FAIL b2b te c=%0d got=%b", c, te_b);
      end
      total++;
      if (if_b !== 5'(exp_if[c])) begin
        bad++;
        $display("[TB] FAIL b2b in_flight c=%0d got=%0d exp=%0d", c, if_b, exp_if[c]);
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (done_b !== 16'd3) begin
      bad++;
      $display("[TB] FAIL b2b txn_done got=%0d exp=3", done_b);
    end
    total++;
    if (rej_b !== 8'd0) begin
      bad++;
      $display("[TB] FAIL b2b rej_cnt got=%0d exp=0", rej_b);
    end
  endtask

  // One-in-flight mode with a rejected trig, NUM_CKS=2.
  task automatic test_no_overlap();
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      trig_c = (c == 5 || c == 6 || c == 9);
      mode_c = 2'b00;
      @(negedge clk);
      total++;
      if (rdy_c !== !((c >= 6 && c <= 8) || (c >= 10 && c <= 12))) begin
        bad++;
        $display("[TB] FAIL noovl ready c=%0d got=%b", c, rdy_c);
      end
      total++;
      if (se_c !== (c == 6 || c == 10)) begin
        bad++;
        $display("[TB] FAIL noovl se c=%0d got=%b", c, se_c);
      end
      total++;
      if (te_c !== (c == 8 || c == 12)) begin
        bad++;
        $display("[TB] FAIL noovl te c=%0d got=%b", c, te_c);
      end
      total++;
      if (rej_c !== ((c >= 7) ? 8'd1 : 8'd0)) begin
        bad++;
        $display("[TB] FAIL noovl rej_cnt c=%0d got=%0d", c, rej_c);
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (done_c !== 16'd2) begin
      bad++;
      $display("[TB] FAIL noovl txn_done got=%0d exp=2", done_c);
    end
  endtask

  // Drop, late and orphan modes, NUM_CKS=1; err_mode toggles when idle.
  task automatic test_err_modes();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      trig_d = (c == 2 || c == 8 || c == 14);
      mode_d = (c == 2) ? 2'b01 : (c == 8) ? 2'b10 : (c == 14) ? 2'b11 : 2'(c);
      @(negedge clk);
      total++;
      if (se_d !== (c == 3 || c == 9)) begin
        bad++;
        $display("[TB] FAIL errmode se c=%0d got=%b", c, se_d);
      end
      total++;
      if (te_d !== (c == 11 || c == 16)) begin
        bad++;
        $display("[TB] FAIL errmode te c=%0d got=%b", c, te_d);
      end
      total++;
      if (if_d !== (((c >= 3 && c <= 4) || (c >= 9 && c <= 11) || (c >= 15 && c <= 16)) ? 5'd1 : 5'd0)) begin
        bad++;
        $display("[TB] FAIL errmode in_flight c=%0d got=%0d", c, if_d);
      end
      total++;
      if (done_d !== ((c >= 17) ? 16'd3 : (c >= 12) ? 16'd2 : (c >= 5) ? 16'd1 : 16'd0)) begin
        bad++;
        $display("[TB] FAIL errmode txn_done c=%0d got=%0d", c, done_d);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset asserted while three transactions are pending, NUM_CKS=4.
  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      trig_e = (c >= 10 && c <= 12);
      mode_e = 2'b00;
      @(negedge clk);
      total++;
      if (se_e !== (c == 11 || c == 12)) begin
        bad++;
        $display("[TB] FAIL rstmid se c=%0d got=%b", c, se_e);
      end
      @(posedge clk);
      #1;
    end
    trig_e = 1'b0;
    total++;
    if (se_e !== 1'b1 || if_e !== 5'd3) begin
      bad++;
      $display("[TB] FAIL rstmid pre-reset se=%b in_flight=%0d exp se=1 in_flight=3", se_e, if_e);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({se_e, te_e, if_e, done_e} !== 23'd0) begin
      bad++;
      $display("[TB] FAIL rstmid async clear got=%h exp=0", {se_e, te_e, if_e, done_e});
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      total++;
      if ({se_e, te_e, if_e, done_e} !== 23'd0) begin
        bad++;
        $display("[TB] FAIL rstmid after release c=%0d got=%h exp=0", c, {se_e, te_e, if_e, done_e});
      end
      @(posedge clk);
      #1;
    end
  endtask

  // trig held for 400 cycles without overlap, NUM_CKS=1: accepts every
  // third cycle (134 total) and 266 rejections saturate rej_cnt at 255.
  task automatic test_saturate();
    int se_count;
    int exp_rej;
    se_count = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      trig_d = 1'b1;
      mode_d = 2'b00;
      @(negedge clk);
      if (se_d === 1'b1) se_count++;
      exp_rej = c - (c + 2) / 3;
      if (exp_rej > 255) exp_rej = 255;
      total++;
      if (rdy_d !== (c % 3 == 0)) begin
        bad++;
        $display("[TB] FAIL sat ready c=%0d got=%b", c, rdy_d);
      end
      total++;
      if (se_d !== (c >= 1 && (c - 1) % 3 == 0)) begin
        bad++;
        $display("[TB] FAIL sat se c=%0d got=%b", c, se_d);
      end
      total++;
      if (rej_d !== 8'(exp_rej)) begin
        bad++;
        $display("[TB] FAIL sat rej_cnt c=%0d got=%0d exp=%0d", c, rej_d, exp_rej);
      end
      @(posedge clk);
      #1;
    end
    trig_d = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (se_d === 1'b1) se_count++;
      @(posedge clk);
      #1;
    end
    total++;
    if (se_count != 134) begin
      bad++;
      $display("[TB] FAIL sat start pulses got=%0d exp=134", se_count);
    end
    total++;
    if (done_d !== 16'(se_count)) begin
      bad++;
      $display("[TB] FAIL sat txn_done got=%0d exp=%0d", done_d, se_count);
    end
    total++;
    if (rej_d !== 8'd255) begin
      bad++;
      $display("[TB] FAIL sat rej_cnt final got=%0d exp=255", rej_d);
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_no_overlap();
    test_err_modes();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
